// File: rtl/news_dispense_arbiter.sv
// Two-kiosk newspaper vending controller sharing one dispenser.
// Kiosks accumulate credit; a round-robin FSM grants the dispenser and returns change or refunds.
module news_dispense_arbiter #(
  parameter int unsigned PRICE   = 15,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] coin0,
  input  logic [1:0] coin1,
  input  logic       disp_ack,
  output logic       disp_req,
  output logic       disp_id,
  output logic       news0,
  output logic       news1,
  output logic       chg_valid,
  output logic [4:0] chg_amt,
  output logic       refund_valid,
  output logic [4:0] refund_amt,
  output logic       coin_rej0,
  output logic       coin_rej1
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0] PriceC = 5'(PRICE);
  localparam logic [5:0] MaxC   = 6'(PRICE + 5);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [4:0]    credit0_q, credit0_d, credit1_q, credit1_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          id_d;
  logic          pend0, pend1;
  logic [4:0]    served_credit;
  logic [5:0]    sum0, sum1;

  function automatic logic [5:0] coin_value(input logic [1:0] coin);
    unique case (coin)
      2'b01:   coin_value = 6'd5;
      2'b10:   coin_value = 6'd10;
      default: coin_value = 6'd0;
    endcase
  endfunction

  always_comb begin
    pend0         = credit0_q >= PriceC;
    pend1         = credit1_q >= PriceC;
    served_credit = disp_id ? credit1_q : credit0_q;
    sum0          = {1'b0, credit0_q} + coin_value(coin0);
    sum1          = {1'b0, credit1_q} + coin_value(coin1);

    credit0_d = credit0_q;
    credit1_d = credit1_q;
    // Saturating add only when the kiosk is not already holding a sale
    if (!pend0) credit0_d = (sum0 > MaxC) ? MaxC[4:0] : sum0[4:0];
    if (!pend1) credit1_d = (sum1 > MaxC) ? MaxC[4:0] : sum1[4:0];

    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    id_d    = disp_id;
    unique case (state_q)
      IDLE: begin
        if (pend0 || pend1) begin
          id_d    = (pend0 && pend1) ? rr_q : pend1;
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (disp_ack)               state_d = DONE;
        else if (cnt_q == CntLast)  state_d = FAULT;
        else                        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        if (disp_id) credit1_d = '0;
        else         credit0_d = '0;
        rr_d    = ~disp_id;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      credit0_q    <= '0;
      credit1_q    <= '0;
      rr_q         <= 1'b0;
      cnt_q        <= '0;
      disp_req     <= 1'b0;
      disp_id      <= 1'b0;
      news0        <= 1'b0;
      news1        <= 1'b0;
      chg_valid    <= 1'b0;
      chg_amt      <= '0;
      refund_valid <= 1'b0;
      refund_amt   <= '0;
      coin_rej0    <= 1'b0;
      coin_rej1    <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit0_q    <= credit0_d;
      credit1_q    <= credit1_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      disp_req     <= (state_d == REQ);
      disp_id      <= id_d;
      news0        <= (state_d == DONE) && !id_d;
      news1        <= (state_d == DONE) && id_d;
      chg_valid    <= (state_d == DONE);
      chg_amt      <= (state_d == DONE) ? served_credit - PriceC : 5'd0;
      refund_valid <= (state_d == FAULT);
      refund_amt   <= (state_d == FAULT) ? served_credit : 5'd0;
      coin_rej0    <= (coin_value(coin0) != 6'd0) && pend0;
      coin_rej1    <= (coin_value(coin1) != 6'd0) && pend1;
    end
  end

endmodule

// File: tb/tb_news_dispense_arbiter.sv
// Directed vector table followed by randomized traffic against a behavioural kiosk model.
module tb_news_dispense_arbiter;

  localparam int unsigned PRICE   = 15;
  localparam int unsigned TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset, disp_ack;
  logic [1:0] coin0, coin1;
  logic       disp_req, disp_id, news0, news1, chg_valid, refund_valid, coin_rej0, coin_rej1;
  logic [4:0] chg_amt, refund_amt;

  news_dispense_arbiter #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .coin0(coin0), .coin1(coin1), .disp_ack(disp_ack),
    .disp_req(disp_req), .disp_id(disp_id), .news0(news0), .news1(news1),
    .chg_valid(chg_valid), .chg_amt(chg_amt), .refund_valid(refund_valid),
    .refund_amt(refund_amt), .coin_rej0(coin_rej0), .coin_rej1(coin_rej1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic        ack;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [17:0] pk(input logic dr, input logic id, input logic n0,
                                     input logic n1, input logic cv, input logic [4:0] ca,
                                     input logic rv, input logic [4:0] ra, input logic j0,
                                     input logic j1);
    return {dr, id, n0, n1, cv, ca, rv, ra, j0, j1};
  endfunction

  task automatic add(input logic rst, input logic [1:0] c0, input logic [1:0] c1,
                     input logic ack, input logic dr, input logic id, input logic n0,
                     input logic n1, input logic cv, input logic [4:0] ca, input logic rv,
                     input logic [4:0] ra, input logic j0, input logic j1);
    vec_t v;
    v.rst = rst; v.c0 = c0; v.c1 = c1; v.ack = ack;
    v.exp = pk(dr, id, n0, n1, cv, ca, rv, ra, j0, j1);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [17:0] exp);
    logic [17:0] act;
    act = {disp_req, disp_id, news0, news1, chg_valid, chg_amt, refund_valid, refund_amt,
           coin_rej0, coin_rej1};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got req=%b id=%b n0=%b n1=%b cv=%b ca=%0d rv=%b ra=%0d rj=%b%b, expected req=%b id=%b n0=%b n1=%b cv=%b ca=%0d rv=%b ra=%0d rj=%b%b",
                  name, act[17], act[16], act[15], act[14], act[13], act[12:8], act[7],
                  act[6:2], act[1], act[0], exp[17], exp[16], exp[15], exp[14], exp[13],
                  exp[12:8], exp[7], exp[6:2], exp[1], exp[0]);
  endtask

  // Behavioural model: phase 0 waiting, 1 requesting, 2 sold, 3 dispenser fault
  int m_credit[2];
  int m_phase, m_id, m_rr, m_cnt;

  task automatic model_step(input logic rst, input logic [1:0] c0, input logic [1:0] c1,
                            input logic ack, output logic [17:0] e);
    int  oldc[2];
    int  val[2];
    bit  rej[2];
    bit  p0, p1;
    int  ca, ra;
    if (rst) begin
      m_credit[0] = 0; m_credit[1] = 0;
      m_phase = 0; m_id = 0; m_rr = 0; m_cnt = 0;
      e = '0;
      return;
    end
    oldc[0] = m_credit[0]; oldc[1] = m_credit[1];
    val[0] = (c0 == 2'b01) ? 5 : (c0 == 2'b10) ? 10 : 0;
    val[1] = (c1 == 2'b01) ? 5 : (c1 == 2'b10) ? 10 : 0;
    for (int k = 0; k < 2; k++) begin
      rej[k] = (val[k] > 0) && (oldc[k] >= PRICE);
      if (oldc[k] < PRICE)
        m_credit[k] = (oldc[k] + val[k] > PRICE + 5) ? PRICE + 5 : oldc[k] + val[k];
    end
    p0 = oldc[0] >= PRICE;
    p1 = oldc[1] >= PRICE;
    case (m_phase)
      0: if (p0 || p1) begin
        m_id = (p0 && p1) ? m_rr : (p0 ? 0 : 1);
        m_phase = 1;
        m_cnt = 0;
      end
      1: begin
        if (ack) m_phase = 2;
        else if (m_cnt == TIMEOUT - 1) m_phase = 3;
        else m_cnt++;
      end
      default: begin
        m_credit[m_id] = 0;
        m_rr = 1 - m_id;
        m_phase = 0;
      end
    endcase
    ca = (m_phase == 2) ? m_credit[m_id] - PRICE : 0;
    ra = (m_phase == 3) ? m_credit[m_id] : 0;
    e = pk(m_phase == 1, m_id[0], (m_phase == 2) && (m_id == 0), (m_phase == 2) && (m_id == 1),
           m_phase == 2, 5'(ca), m_phase == 3, 5'(ra), rej[0], rej[1]);
  endtask

  initial begin
    logic [17:0] e;
    reset = 1'b1; coin0 = 2'b00; coin1 = 2'b00; disp_ack = 1'b0;

    //  rst c0 c1 ack | req id n0 n1 cv ca rv ra j0 j1
    add(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 2, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 2, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 2, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1,  0, 1, 0, 1, 1, 5, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2, 2, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 2, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 15, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; coin0 = vecs[i].c0; coin1 = vecs[i].c1; disp_ack = vecs[i].ack;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      reset    = (i == 0) || ($urandom_range(0, 99) == 0);
      coin0    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      coin1    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      disp_ack = ($urandom_range(0, 4) == 0);
      @(posedge clk);
      #1;
      model_step(reset, coin0, coin1, disp_ack, e);
      check($sformatf("rand%0d", i), e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/news_dispense_arbiter.md
NEWS_DISPENSE_ARBITER -- requirements
Module: news_dispense_arbiter

Interface
REQ-001 Parameter PRICE, default 15, sale price in credit units; legal values 5, 10, 15, 20.
REQ-002 Parameter TIMEOUT, default 8, number of REQ-state cycles allowed before a dispenser fault.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 coin0  input  2  kiosk 0 coin: 2'b01 = 5, 2'b10 = 10, 2'b00/2'b11 = no coin; one cycle per coin.
REQ-006 coin1  input  2  kiosk 1 coin, same encoding as coin0.
REQ-007 disp_ack  input  1  one-cycle pulse from the shared dispenser: item dropped.
REQ-008 disp_req  output  1  dispense request to the shared dispenser.
REQ-009 disp_id  output  1  kiosk currently being served; valid while disp_req=1.
REQ-010 news0, news1  output  1 each  one-cycle "item delivered" pulse per kiosk.
REQ-011 chg_valid  output  1  one-cycle change-return strobe.
REQ-012 chg_amt  output  5  change amount; valid when chg_valid=1, otherwise 0.
REQ-013 refund_valid  output  1  one-cycle full-refund strobe after a dispenser fault.
REQ-014 refund_amt  output  5  refund amount; valid when refund_valid=1, otherwise 0.
REQ-015 coin_rej0, coin_rej1  output  1 each  pulse one cycle after a rejected coin.

Function
REQ-016 Each kiosk has a 5-bit credit register; an accepted coin adds 5 or 10 at the next edge.
REQ-017 A kiosk is pending while credit >= PRICE.
REQ-018 A coin arriving at a pending kiosk is not added; that kiosk's coin_rej pulses at the next edge.
REQ-019 Coins of value 2'b11 have no effect and produce no reject.
REQ-020 Maximum credit is PRICE+5; the credit register never wraps.
REQ-021 Control FSM states: IDLE, REQ, DONE, FAULT.
REQ-022 IDLE with no pending kiosk: remain in IDLE.
REQ-023 IDLE with at least one pending kiosk: the winner is latched into disp_id, the FSM enters REQ, and the REQ-cycle counter clears.
REQ-024 Arbitration: a lone pending kiosk wins; with both pending, the kiosk indicated by round-robin pointer rr wins.
REQ-025 REQ: disp_req=1 and disp_id is held stable for the whole state.
REQ-026 REQ with disp_ack=1: next state is DONE.
REQ-027 REQ without ack when the counter reaches TIMEOUT-1: next state is FAULT; otherwise the counter increments.
REQ-028 DONE, exactly one cycle: news[disp_id]=1, chg_valid=1, chg_amt = credit[disp_id] - PRICE (0 allowed), then IDLE.
REQ-029 FAULT, exactly one cycle: refund_valid=1, refund_amt = credit[disp_id], no news pulse, then IDLE.
REQ-030 On leaving DONE or FAULT: credit[disp_id] clears to 0 and rr is set to the other kiosk.
REQ-031 Coins to the non-served kiosk are accepted in every state.
REQ-032 disp_ack outside REQ is ignored.
REQ-033 Simultaneous coins on both kiosks are each processed independently in the same cycle.
REQ-034 Latency: credit reaching PRICE at edge N gives disp_req=1 after edge N+1 when the FSM is in IDLE at edge N+1.
REQ-035 All outputs are registered.

Reset
REQ-036 When reset=1 at a rising edge: FSM=IDLE, both credits=0, rr=0 (kiosk 0 favoured), REQ-cycle counter=0, all outputs 0.
REQ-037 Reset asserted in REQ, DONE or FAULT aborts the transaction: no news, change or refund pulse; credit is lost.
REQ-038 Coins sampled in the same cycle as reset=1 are discarded.

Verification
REQ-039 Kiosk 0 coins 5,5,5, ack 2 cycles after disp_req -> disp_id=0, news0 pulse, chg_valid with chg_amt=0, credit0=0.
REQ-040 Kiosk 1 coins 10,10 -> disp_id=1, news1 pulse, chg_amt=5 on ack; a third coin after reaching 20 -> coin_rej1 pulse, credit stays 20.
REQ-041 Both kiosks reach 15 in the same cycle after reset -> kiosk 0 served first, then kiosk 1, with rr alternating.
REQ-042 Kiosk 0 reaches 15 and disp_ack is never sent -> disp_req high for exactly 8 cycles, then refund_valid with refund_amt=15, no news0.
REQ-043 Reset asserted while in REQ for kiosk 1 -> all outputs 0 next cycle, credit1=0, no pulses.
REQ-044 Kiosk 1 inserts coins while kiosk 0 is in REQ -> kiosk 1 credit accumulates and it is granted immediately after kiosk 0's DONE cycle.
